isp_boot_ctrl: RTL and testbench

Boot sequencer for `RISC_V_Core`. It holds the core in reset and streams program bytes into instruction memory through the core's `isp_*` write port. It then releases reset and pulses `start` with the program entry address. It sits between a byte-stream loader (UART/debug bridge) and the core, and replaces the bench-driven reset/start/`$readmemh` sequence in hardware builds.

---
 rtl/isp_boot_ctrl_pkg.sv | 23 ++
 rtl/isp_boot_ctrl_if.sv | 51 +++++
 rtl/isp_word_packer.sv | 49 ++++
 rtl/isp_boot_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_isp_boot_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/isp_boot_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// isp_boot_pkg
// Shared types and constants for the boot sequencer that loads a program into
// the RISC_V_Core instruction memory through its isp_* write port.
//   state_t        : sequencer states, in the order a load walks through them
//   BYTES_PER_WORD : bytes packed into one ISP word
//   PROG_ADDR_W    : width of the core's prog_address input
// -----------------------------------------------------------------------------
package isp_boot_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOLD    = 3'd1,
        RECV    = 3'd2,
        WRITE   = 3'd3,
        RELEASE = 3'd4,
        START   = 3'd5
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int PROG_ADDR_W    = 20;

endpackage

// File: rtl/isp_boot_ctrl_if.sv
// -----------------------------------------------------------------------------
// isp_boot_ctrl_if
// Bundles every signal between the boot sequencer, the byte-stream loader that
// feeds it and the core it boots.
//   Loader side  : load_req/load_base/load_count, byte_valid/byte_data/byte_ready
//   Core side    : core_reset, isp_write/isp_address/isp_data, start, prog_address
//   Status       : busy, done, fsm_state (sequencer state for observation)
//
// Byte handshake: a byte moves on a rising clock edge where byte_valid and
// byte_ready are both high. byte_data must be stable while byte_valid is high;
// byte_valid with byte_ready low moves nothing and may be withdrawn freely.
//
// Modports:
//   master : the loader / host side (drives requests and bytes)
//   slave  : the sequencer (isp_boot_ctrl)
// -----------------------------------------------------------------------------
interface isp_boot_ctrl_if #(
    parameter int ADDRESS_BITS = 12,
    parameter int DATA_WIDTH   = 32
);
    import isp_boot_pkg::*;

    logic                    load_req;
    logic [ADDRESS_BITS-1:0] load_base;
    logic [ADDRESS_BITS:0]   load_count;
    logic                    byte_valid;
    logic [7:0]              byte_data;
    logic                    byte_ready;
    logic                    core_reset;
    logic                    isp_write;
    logic [ADDRESS_BITS-1:0] isp_address;
    logic [DATA_WIDTH-1:0]   isp_data;
    logic                    start;
    logic [PROG_ADDR_W-1:0]  prog_address;
    logic                    busy;
    logic                    done;
    state_t                  fsm_state;

    modport master (
        output load_req, load_base, load_count, byte_valid, byte_data,
        input  byte_ready, core_reset, isp_write, isp_address, isp_data,
               start, prog_address, busy, done, fsm_state
    );

    modport slave (
        input  load_req, load_base, load_count, byte_valid, byte_data,
        output byte_ready, core_reset, isp_write, isp_address, isp_data,
               start, prog_address, busy, done, fsm_state
    );

endinterface

// File: rtl/isp_word_packer.sv
// -----------------------------------------------------------------------------
// isp_word_packer
// Packs an accepted byte stream little-endian into ISP words: the first byte
// of a word lands in [7:0], the last in the top byte.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   clear        : discard any partial word and restart at byte 0
//   byte_valid   : a byte is accepted this cycle (already qualified by ready)
//   byte_data    : the byte
//   word         : packed word, meaningful in the cycle word_full is high
//   word_full    : the byte accepted this cycle completes a word
// -----------------------------------------------------------------------------
module isp_word_packer
    import isp_boot_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          byte_valid,
    input  logic [7:0]                    byte_data,
    output logic [BYTES_PER_WORD*8-1:0]   word,
    output logic                          word_full
);

    localparam int CNT_W   = $clog2(BYTES_PER_WORD);
    localparam int SHIFT_W = (BYTES_PER_WORD - 1) * 8;

    logic [CNT_W-1:0]   byte_cnt_q;
    logic [SHIFT_W-1:0] shift_q;

    // Only the first three bytes are stored; the completing byte is merged
    // combinationally so the word is available in the same cycle it arrives.
    assign word_full = byte_valid && (byte_cnt_q == CNT_W'(BYTES_PER_WORD - 1));
    assign word      = {byte_data, shift_q};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_cnt_q <= '0;
            shift_q    <= '0;
        end else if (clear) begin
            byte_cnt_q <= '0;
            shift_q    <= '0;
        end else if (byte_valid) begin
            // Counter wraps to 0 after the completing byte.
            byte_cnt_q <= byte_cnt_q + CNT_W'(1);
            shift_q    <= {byte_data, shift_q[SHIFT_W-1:8]};
        end
    end

endmodule

// File: rtl/isp_boot_ctrl.sv
// -----------------------------------------------------------------------------
// isp_boot_ctrl
// Boot sequencer for RISC_V_Core. Holds the core in reset, streams bytes from
// a loader into instruction memory through the isp_* port, releases reset and
// pulses start with the program entry address.
//   Parameters : DATA_WIDTH (ISP word, 32), ADDRESS_BITS (ISP word address),
//                RESET_HOLD (cycles of reset hold before the first byte, >= 1)
//   clock      : rising-edge clock
//   reset      : asynchronous active-high reset
//   bus        : isp_boot_ctrl_if.slave -- loader request + byte stream in,
//                core reset/ISP write/start out, busy/done/fsm_state status
//
// Sequence: IDLE -> HOLD (RESET_HOLD cycles) -> {RECV (4 bytes) -> WRITE} x N
//           -> RELEASE (core_reset low) -> START (start + done) -> IDLE
// -----------------------------------------------------------------------------
module isp_boot_ctrl
    import isp_boot_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 12,
    parameter int RESET_HOLD   = 10
) (
    input  logic           clock,
    input  logic           reset,
    isp_boot_ctrl_if.slave bus
);

    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    state_t                  state_q;
    state_t                  state_d;

    logic [ADDRESS_BITS-1:0] base_q;        // latched entry point
    logic [ADDRESS_BITS-1:0] addr_q;        // base + word index, wraps naturally
    logic [ADDRESS_BITS:0]   remaining_q;   // words still to be written
    logic [HOLD_W-1:0]       hold_q;

    // Registered outputs and their next values
    logic                    core_reset_q,   core_reset_d;
    logic [ADDRESS_BITS-1:0] isp_address_q,  isp_address_d;
    logic [DATA_WIDTH-1:0]   isp_data_q,     isp_data_d;
    logic [PROG_ADDR_W-1:0]  prog_address_q, prog_address_d;

    // Outputs decoded straight from the state register
    logic byte_ready;
    logic isp_write;
    logic start_pulse;
    logic busy;

    // Packer connections
    logic                        byte_fire;
    logic                        packer_clear;
    logic [BYTES_PER_WORD*8-1:0] packed_word;
    logic                        word_full;

    logic accept_req;

    assign accept_req   = (state_q == IDLE) && bus.load_req;
    assign byte_fire    = byte_ready && bus.byte_valid;
    // Holding the packer clear in IDLE guarantees every load starts at byte 0.
    assign packer_clear = (state_q == IDLE);

    isp_word_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (packer_clear),
        .byte_valid (byte_fire),
        .byte_data  (bus.byte_data),
        .word       (packed_word),
        .word_full  (word_full)
    );

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.load_req) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    state_d = (remaining_q == '0) ? RELEASE : RECV;
                end
            end
            RECV: begin
                if (word_full) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // remaining_q still counts the word being written now.
                state_d = (remaining_q == (ADDRESS_BITS+1)'(1)) ? RELEASE : RECV;
            end
            RELEASE: state_d = START;
            START:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: output logic (state decodes + next values of registered outputs)
    // ---------------------------------------------------------------------
    always_comb begin
        byte_ready     = (state_q == RECV);
        isp_write      = (state_q == WRITE);
        start_pulse    = (state_q == START);
        busy           = (state_q != IDLE);

        core_reset_d   = core_reset_q;
        isp_address_d  = isp_address_q;
        isp_data_d     = isp_data_q;
        prog_address_d = prog_address_q;

        // A new load always re-asserts core reset; otherwise IDLE leaves it
        // where the previous load (or power-on reset) put it.
        if (accept_req) begin
            core_reset_d = 1'b1;
        end

        if (state_d == RELEASE) begin
            core_reset_d = 1'b0;
        end

        // Capture address and word on the completing byte so both are
        // stable registers for the single WRITE cycle.
        if ((state_q == RECV) && word_full) begin
            isp_address_d = addr_q;
            isp_data_d    = DATA_WIDTH'(packed_word);
        end

        if (state_d == START) begin
            prog_address_d = PROG_ADDR_W'(base_q);
        end
    end

    // ---------------------------------------------------------------------
    // Counters, latched request and registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base_q         <= '0;
            addr_q         <= '0;
            remaining_q    <= '0;
            hold_q         <= '0;
            core_reset_q   <= 1'b1;
            isp_address_q  <= '0;
            isp_data_q     <= '0;
            prog_address_q <= '0;
        end else begin
            core_reset_q   <= core_reset_d;
            isp_address_q  <= isp_address_d;
            isp_data_q     <= isp_data_d;
            prog_address_q <= prog_address_d;

            if (accept_req) begin
                base_q      <= bus.load_base;
                addr_q      <= bus.load_base;
                remaining_q <= bus.load_count;
                hold_q      <= HOLD_W'(RESET_HOLD - 1);
            end

            if ((state_q == HOLD) && (hold_q != '0)) begin
                hold_q <= hold_q - HOLD_W'(1);
            end

            if (state_q == WRITE) begin
                addr_q      <= addr_q + ADDRESS_BITS'(1);
                remaining_q <= remaining_q - (ADDRESS_BITS+1)'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Interface outputs
    // ---------------------------------------------------------------------
    assign bus.byte_ready   = byte_ready;
    assign bus.core_reset   = core_reset_q;
    assign bus.isp_write    = isp_write;
    assign bus.isp_address  = isp_address_q;
    assign bus.isp_data     = isp_data_q;
    assign bus.start        = start_pulse;
    assign bus.prog_address = prog_address_q;
    assign bus.busy         = busy;
    assign bus.done         = start_pulse;
    assign bus.fsm_state    = state_q;

endmodule

// File: tb/tb_isp_boot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_isp_boot_ctrl
// Scoreboard bench for isp_boot_ctrl. Each load pushes its expected ISP writes
// and start event into exp_q; a negedge monitor pops one entry whenever the
// DUT shows isp_write or start and compares it.
// Entry layout: [52] kind (1 = start), [51:32] address, [31:0] data, or for a
// start the expected load_req-to-start latency (NO_LAT = not checked).
// -----------------------------------------------------------------------------
module tb_isp_boot_ctrl;
    import isp_boot_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int RH = 10;
    localparam int W  = 53;
    localparam logic [31:0] NO_LAT = 32'hFFFF_FFFF;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    isp_boot_ctrl_if #(.ADDRESS_BITS(AW), .DATA_WIDTH(DW)) bus ();

    isp_boot_ctrl #(
        .DATA_WIDTH   (DW),
        .ADDRESS_BITS (AW),
        .RESET_HOLD   (RH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [W-1:0] exp_q[$];
    logic [7:0]   stim_bytes[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int req_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic       prev_write = 1'b0;
    logic [1:0] rst_hist   = 2'b11;   // {two cycles ago, one cycle ago}

    always @(negedge clock) begin
        logic [W-1:0] act;
        logic [W-1:0] exp;
        if (reset) begin
            prev_write = 1'b0;
            rst_hist   = 2'b11;
        end else begin
            if (bus.isp_write) begin
                check("write_single_cycle", 64'(prev_write), 64'd0);
                check("write_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp = exp_q.pop_front();
                    act = {1'b0, 20'(bus.isp_address), bus.isp_data};
                    check("isp_write_item", 64'(act), 64'(exp));
                end
            end
            if (bus.start) begin
                check("start_no_write", 64'(bus.isp_write), 64'd0);
                check("start_done", 64'(bus.done), 64'd1);
                check("core_reset_falls_before_start", 64'(rst_hist), 64'b10);
                check("start_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp = exp_q.pop_front();
                    act = {1'b1, bus.prog_address, 32'(cyc - req_cyc + 1)};
                    if (exp[31:0] == NO_LAT) act[31:0] = NO_LAT;
                    check("start_item", 64'(act), 64'(exp));
                end
            end
            prev_write = bus.isp_write;
            rst_hist   = {rst_hist[0], bus.core_reset};
        end
    end

    // ------------------------------------------------------------------
    // Driver: one load of 'count' words taken from stim_bytes.
    // valid_mode 0 = continuous, 1 = toggle every cycle, 2 = random.
    // abort_after >= 0 asserts reset once that many bytes have transferred.
    // ------------------------------------------------------------------
    task automatic run_load(input logic [AW-1:0] base, input int count,
                            input int valid_mode, input int abort_after);
        int nbytes;
        int stop_bytes;
        int idx;
        int guard;
        bit bv;
        logic [31:0] w;

        nbytes     = count * 4;
        stop_bytes = (abort_after >= 0) ? abort_after : nbytes;

        // Reference model: word i is bytes 4i..4i+3 little-endian at
        // (base + i) mod 2^AW; a completed load ends with a start at base.
        for (int i = 0; i < count; i++) begin
            w = {stim_bytes[4*i+3], stim_bytes[4*i+2], stim_bytes[4*i+1], stim_bytes[4*i]};
            if (abort_after < 0 || (4*i + 4) <= abort_after)
                exp_q.push_back({1'b0, 20'((int'(base) + i) % (1 << AW)), w});
        end
        if (abort_after < 0)
            exp_q.push_back({1'b1, 20'(base),
                             (valid_mode == 0) ? 32'(RH + 5*count + 2) : NO_LAT});

        @(negedge clock);
        bus.load_base  = base;
        bus.load_count = 13'(count);
        bus.load_req   = 1'b1;
        @(negedge clock);
        req_cyc        = cyc;
        bus.load_req   = 1'b0;
        bus.load_base  = 12'($urandom);    // must already be latched
        bus.load_count = 13'($urandom_range(0, 4096));

        idx   = 0;
        guard = 0;
        bv    = 1'b0;
        while (idx < stop_bytes && guard < 4000) begin
            case (valid_mode)
                0:       bv = 1'b1;
                1:       bv = ~bv;
                default: bv = 1'($urandom_range(0, 1));
            endcase
            bus.byte_valid = bv;
            bus.byte_data  = stim_bytes[idx];
            if (bv && bus.byte_ready) idx++;
            @(negedge clock);
            guard++;
        end
        bus.byte_valid = 1'b0;
        check("bytes_consumed", 64'(idx), 64'(stop_bytes));

        if (abort_after >= 0) begin
            reset = 1'b1;
            #1;
            check("abort_core_reset", 64'(bus.core_reset), 64'd1);
            check("abort_byte_ready", 64'(bus.byte_ready), 64'd0);
            check("abort_isp_write", 64'(bus.isp_write), 64'd0);
            check("abort_isp_address", 64'(bus.isp_address), 64'd0);
            check("abort_isp_data", 64'(bus.isp_data), 64'd0);
            check("abort_start", 64'(bus.start), 64'd0);
            check("abort_busy", 64'(bus.busy), 64'd0);
            check("abort_prog_address", 64'(bus.prog_address), 64'd0);
            check("abort_state", 64'(bus.fsm_state), 64'(IDLE));
            check("abort_queue_empty", 64'(exp_q.size()), 64'd0);
            @(negedge clock);
            @(negedge clock);
            reset = 1'b0;
        end else begin
            guard = 0;
            while (!bus.done && guard < 200) begin
                @(negedge clock);
                guard++;
            end
            check("done_seen", 64'(bus.done), 64'd1);
            repeat (3) @(negedge clock);
            check("prog_address_hold", 64'(bus.prog_address), 64'(base));
            check("core_reset_stays_low", 64'(bus.core_reset), 64'd0);
            check("busy_idle", 64'(bus.busy), 64'd0);
        end
    endtask

    task automatic fill_random(input int count);
        stim_bytes.delete();
        for (int i = 0; i < count * 4; i++) stim_bytes.push_back(8'($urandom_range(0, 255)));
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bus.load_req   = 1'b0;
        bus.load_base  = '0;
        bus.load_count = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;

        repeat (3) @(negedge clock);
        check("rst_core_reset", 64'(bus.core_reset), 64'd1);
        check("rst_byte_ready", 64'(bus.byte_ready), 64'd0);
        check("rst_start", 64'(bus.start), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_prog_address", 64'(bus.prog_address), 64'd0);
        reset = 1'b0;

        // Idle with byte noise: nothing may move and the core stays in reset.
        for (int i = 0; i < 20; i++) begin
            bus.byte_valid = 1'($urandom_range(0, 1));
            bus.byte_data  = 8'($urandom);
            @(negedge clock);
            check("idle_core_reset", 64'(bus.core_reset), 64'd1);
            check("idle_byte_ready", 64'(bus.byte_ready), 64'd0);
            check("idle_start", 64'(bus.start), 64'd0);
        end
        bus.byte_valid = 1'b0;

        // Directed program, continuous then toggling valid.
        stim_bytes = {8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        run_load(12'h010, 2, 0, -1);
        run_load(12'h010, 2, 1, -1);

        // Address wrap at the top of memory.
        fill_random(2);
        run_load(12'hFFF, 2, 0, -1);

        // Empty load: no writes, start after the hold only.
        stim_bytes.delete();
        run_load(12'h123, 0, 0, -1);

        // Reset after two bytes of the second word, then a normal load.
        fill_random(2);
        run_load(12'h020, 2, 0, 6);
        fill_random(3);
        run_load(12'h040, 3, 0, -1);

        // Random loads.
        for (int t = 0; t < 12; t++) begin
            int cnt;
            cnt = $urandom_range(0, 6);
            fill_random(cnt);
            run_load(12'($urandom), cnt, $urandom_range(0, 2), -1);
        end

        repeat (10) @(negedge clock);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
